uart_rx_ctrl: RTL

- Frame sequencer for the UART receiver. Owns the per-bit edge counter and the frame bit counter.
- Drives the enables of the sampler, deserializer, start, parity and stop checkers, and consumes their error flags.
- Emits a single-cycle data_valid, or an error pulse, at the end of each frame.
- Sits between RX_IN and the receiver datapath blocks. Purely a controller: it carries no data bits.

---
 rtl/uart_rx_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// ============================================================================
// Module   : uart_rx_ctrl
// Purpose  : UART receive frame sequencer; times each bit and strobes the
//            sampler, deserializer and start/parity/stop checkers.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int EDGE_W     = 6,
    parameter int BIT_W      = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_IN,
    input  logic              PAR_EN,
    input  logic [EDGE_W-1:0] Prescale,
    input  logic              strt_glitch,
    input  logic              par_err,
    input  logic              stp_err,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]  bit_cnt,
    output logic              dat_samp_en,
    output logic              strt_chk_en,
    output logic              deser_en,
    output logic              par_chk_en,
    output logic              stp_chk_en,
    output logic              data_valid,
    output logic              frame_err,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [EDGE_W-1:0] P8         = EDGE_W'(8);
    localparam logic [EDGE_W-1:0] P16        = EDGE_W'(16);
    localparam logic [EDGE_W-1:0] P32        = EDGE_W'(32);
    localparam logic [BIT_W-1:0]  LAST_DATA  = BIT_W'(DATA_WIDTH);

    state_t            state_q, state_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic [EDGE_W-1:0] pre_q, pre_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              par_en_q, par_en_d;
    logic              par_flag_q, par_flag_d;
    logic              strt_q, strt_d;
    logic              deser_q, deser_d;
    logic              par_q, par_d;
    logic              stp_q, stp_d;
    logic              dv_q, dv_d;
    logic              fe_q, fe_d;

    logic              w_legal;
    logic              w_at_last;
    logic              w_err;
    logic              w_chk_hit;

    assign w_legal   = (Prescale == P8) || (Prescale == P16) || (Prescale == P32);
    assign w_at_last = (edge_q == (pre_q - EDGE_W'(1)));
    assign w_err     = par_flag_q | stp_err;

    always_comb begin
        state_d    = state_q;
        edge_d     = edge_q;
        bit_d      = bit_q;
        pre_d      = pre_q;
        par_en_d   = par_en_q;
        par_flag_d = par_flag_q;
        dv_d       = 1'b0;
        fe_d       = 1'b0;

        if (state_q == S_IDLE) begin
            edge_d = '0;
            bit_d  = '0;
            if (!RX_IN && w_legal) begin
                state_d    = S_START;
                pre_d      = Prescale;
                par_en_d   = PAR_EN;
                par_flag_d = 1'b0;
            end
        end else if (w_at_last) begin
            edge_d = '0;
            bit_d  = bit_q + BIT_W'(1);
        end else begin
            edge_d = edge_q + EDGE_W'(1);
        end

        case (state_q)
            S_IDLE: ;
            S_START: begin
                if (w_at_last) begin
                    if (strt_glitch) begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_at_last && (bit_q == LAST_DATA)) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_at_last) begin
                    par_flag_d = par_err;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                // Result is registered so the pulse coincides with the first IDLE cycle.
                if (w_at_last) begin
                    state_d = S_IDLE;
                    bit_d   = '0;
                    dv_d    = ~w_err;
                    fe_d    = w_err;
                end
            end
            default: begin
                state_d = S_IDLE;
                edge_d  = '0;
                bit_d   = '0;
            end
        endcase

        // Enables are decoded from next-state values so they leave flops aligned with edge_cnt.
        w_chk_hit = (edge_d == ((pre_d >> 1) + EDGE_W'(2)));
        strt_d    = (state_d == S_START)  && w_chk_hit;
        deser_d   = (state_d == S_DATA)   && w_chk_hit;
        par_d     = (state_d == S_PARITY) && w_chk_hit;
        stp_d     = (state_d == S_STOP)   && w_chk_hit;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            edge_q     <= '0;
            bit_q      <= '0;
            pre_q      <= P8;
            par_en_q   <= 1'b0;
            par_flag_q <= 1'b0;
            strt_q     <= 1'b0;
            deser_q    <= 1'b0;
            par_q      <= 1'b0;
            stp_q      <= 1'b0;
            dv_q       <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_q     <= edge_d;
            bit_q      <= bit_d;
            pre_q      <= pre_d;
            par_en_q   <= par_en_d;
            par_flag_q <= par_flag_d;
            strt_q     <= strt_d;
            deser_q    <= deser_d;
            par_q      <= par_d;
            stp_q      <= stp_d;
            dv_q       <= dv_d;
            fe_q       <= fe_d;
        end
    end

    assign edge_cnt    = edge_q;
    assign bit_cnt     = bit_q;
    assign busy        = (state_q != S_IDLE);
    assign dat_samp_en = (state_q != S_IDLE);
    assign strt_chk_en = strt_q;
    assign deser_en    = deser_q;
    assign par_chk_en  = par_q;
    assign stp_chk_en  = stp_q;
    assign data_valid  = dv_q;
    assign frame_err   = fe_q;

endmodule

`default_nettype wire
